// File: rtl/prom_sequencer_if.sv
// prom_b_if: read-only port B of the pattern PROM.
//   addrb : address presented to the PROM (driven by the sequencer).
//   doutb : 36-bit data word, valid the cycle after addrb is sampled.
// master = sequencer side, slave = PROM side.
interface prom_b_if #(
   parameter int ADDR_BITS = 7
);
   logic [ADDR_BITS-1:0] addrb;
   logic [35:0]          doutb;

   modport master (output addrb, input  doutb);
   modport slave  (input  addrb, output doutb);
endinterface

// File: rtl/prom_sequencer.sv
// prom_sequencer: walks the pattern PROM, shows each word's LED pattern for
// max(count,1) * PRESCALE enabled cycles, then fetches the next word.
// Ports:
//   clk, rst_n : clock (also PROM clkb), asynchronous active-low reset
//   en         : run enable; freezes the hold timers when low
//   restart    : one-cycle request to refetch from address 0
//   prom       : PROM port B (addrb out, registered; doutb in)
//   led        : current pattern, registered
//   step       : high for the LOAD cycle of each word
module prom_sequencer #(
   parameter int ADDR_BITS = 7,
   parameter int LED_WIDTH = 8,
   parameter int PRESCALE  = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 restart,
   prom_b_if.master             prom,
   output logic [LED_WIDTH-1:0] led,
   output logic                 step
);
   localparam int                   PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0]     PRE_RELOAD = PRE_W'(PRESCALE - 1);
   localparam logic [ADDR_BITS-1:0] ADDR_MAX   = '1;

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;

   state_t               state, state_nx;
   logic [23:0]          hold_cnt, hold_nx;
   logic [PRE_W-1:0]     pre_cnt, pre_nx;
   logic [ADDR_BITS-1:0] addr_nx;
   logic [LED_WIDTH-1:0] led_nx;

   logic [23:0] word_cnt;
   logic        word_last;
   logic        unused_rsvd;

   assign word_cnt    = prom.doutb[27:4];
   assign word_last   = prom.doutb[0];
   // reserved bits [3:1] carry no meaning for the sequencer
   assign unused_rsvd = ^prom.doutb;

   // step is a pure decode of LOAD, so it lines up with the word being latched
   assign step = (state == LOAD);

   always_comb begin
      state_nx = state;
      hold_nx  = hold_cnt;
      pre_nx   = pre_cnt;
      addr_nx  = prom.addrb;
      led_nx   = led;
      if (restart) begin
         // wins over everything, including a LOAD in flight (its data is dropped)
         addr_nx  = '0;
         state_nx = FETCH;
      end else begin
         case (state)
            IDLE:  if (en) state_nx = FETCH;
            FETCH: state_nx = LOAD;
            LOAD: begin
               led_nx   = prom.doutb[35 -: LED_WIDTH];
               hold_nx  = (word_cnt == 24'd0) ? 24'd1 : word_cnt;
               pre_nx   = PRE_RELOAD;
               addr_nx  = (word_last || prom.addrb == ADDR_MAX) ? '0
                                                                 : prom.addrb + ADDR_BITS'(1);
               state_nx = HOLD;
            end
            HOLD: begin
               if (en) begin
                  if (pre_cnt != '0)
                     pre_nx = pre_cnt - PRE_W'(1);
                  else if (hold_cnt <= 24'd1)
                     state_nx = FETCH;        // last prescale unit of the last hold unit
                  else begin
                     pre_nx  = PRE_RELOAD;
                     hold_nx = hold_cnt - 24'd1;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         pre_cnt    <= '0;
         prom.addrb <= '0;
         led        <= '0;
      end else begin
         state      <= state_nx;
         hold_cnt   <= hold_nx;
         pre_cnt    <= pre_nx;
         prom.addrb <= addr_nx;
         led        <= led_nx;
      end
   end
endmodule

// File: tb/tb_prom_sequencer.sv
module tb_prom_sequencer;
   localparam int PRE = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       restart = 1'b0;
   logic [7:0] led0, led1;
   logic       step0, step1;

   prom_b_if #(.ADDR_BITS(7)) pa();
   prom_b_if #(.ADDR_BITS(2)) pb();

   prom_sequencer #(.ADDR_BITS(7), .LED_WIDTH(8), .PRESCALE(PRE)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
      .prom(pa), .led(led0), .step(step0));

   prom_sequencer #(.ADDR_BITS(2), .LED_WIDTH(8), .PRESCALE(PRE)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
      .prom(pb), .led(led1), .step(step1));

   always #5 clk = ~clk;

   // behavioural PROMs, one-cycle registered read
   logic [35:0] mem0 [128];
   logic [35:0] mem1 [4];
   always @(posedge clk) pa.doutb <= mem0[pa.addrb];
   always @(posedge clk) pb.doutb <= mem1[pb.addrb];

   int errs = 0, checks = 0, cyc = 0;

   // reference: phase 0 idle, 1 fetch, 2 load, 3 hold; m_rem = enabled hold cycles left
   int         m_phase [2];
   int         m_addr  [2];
   int         m_rem   [2];
   int         m_cnt   [2];
   int         m_idx   [2];
   logic [7:0] m_led   [2];
   int         depth   [2] = '{128, 4};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [35:0] wrd(input int i, input int a);
      return (i == 0) ? mem0[a] : mem1[a];
   endfunction

   task automatic model_rst();
      for (int i = 0; i < 2; i++) begin
         m_phase[i] = 0; m_addr[i] = 0; m_rem[i] = 0;
         m_cnt[i] = 0;   m_idx[i] = 0;  m_led[i] = 8'h00;
      end
   endtask

   task automatic model_step(input int i);
      logic [35:0] w;
      if (restart) begin
         m_phase[i] = 1;
         m_addr[i]  = 0;
      end else begin
         case (m_phase[i])
            0: if (en) m_phase[i] = 1;
            1: m_phase[i] = 2;
            2: begin
               w          = wrd(i, m_addr[i]);
               m_led[i]   = w[35:28];
               m_cnt[i]   = (w[27:4] == 24'd0) ? 1 : int'(w[27:4]);
               m_rem[i]   = m_cnt[i] * PRE;
               m_idx[i]   = m_addr[i];
               m_addr[i]  = w[0] ? 0 : (m_addr[i] + 1) % depth[i];
               m_phase[i] = 3;
            end
            default: if (en) begin
               m_rem[i]--;
               if (m_rem[i] == 0) m_phase[i] = 1;
            end
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step(0);
      model_step(1);
      #1;
      chk("led0",  32'(led0),     32'(m_led[0]));
      chk("addr0", 32'(pa.addrb), m_addr[0]);
      chk("step0", 32'(step0),    32'(m_phase[0] == 2));
      chk("led1",  32'(led1),     32'(m_led[1]));
      chk("addr1", 32'(pb.addrb), m_addr[1]);
      chk("step1", 32'(step1),    32'(m_phase[1] == 2));
   endtask

   task automatic wait_step(input string tag);
      bit ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (step0) begin ok = 1'b1; break; end
      end
      if (!ok) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_phase(input string tag, input int ph, input int idx);
      bit ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (m_phase[0] == ph && (idx < 0 || m_idx[0] == idx)) begin ok = 1'b1; break; end
      end
      if (!ok) chk({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      int         sq[$];
      int         cs, n;
      logic [7:0] exp_led;

      for (int i = 0; i < 128; i++) mem0[i] = '0;
      mem0[0] = {8'h5A, 24'd2, 3'b000, 1'b0};
      mem0[1] = {8'hA5, 24'd0, 3'b000, 1'b0};
      mem0[2] = {8'h3C, 24'd1, 3'b101, 1'b1};
      for (int i = 0; i < 4; i++) mem1[i] = {8'(8'h11 * (i + 1)), 24'd1, 4'b0000};
      model_rst();

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_led0",  32'(led0),     0);
      chk("rst_addr0", 32'(pa.addrb), 0);
      chk("rst_step0", 32'(step0),    0);
      chk("rst_addr1", 32'(pb.addrb), 0);

      // startup timing, zero count, wrap on last / end of space
      rst_n = 1'b1;
      en    = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (step0) sq.push_back(cyc);
         if (cyc == 3) chk("start_led", 32'(led0), 32'h5A);
      end
      chk("start_nsteps", 32'(sq.size() >= 5), 1);
      if (sq.size() >= 5) begin
         chk("start_step", sq[0], 2);
         chk("dwell_cnt2", sq[1] - sq[0], 2 * PRE + 2);
         chk("dwell_cnt0", sq[2] - sq[1], 1 * PRE + 2);
         chk("dwell_last", sq[3] - sq[2], 1 * PRE + 2);
         chk("dwell_wrap", sq[4] - sq[3], 2 * PRE + 2);
      end

      // enable drop mid-HOLD extends the dwell by exactly the dropped cycles
      wait_step("drop");
      cs = cyc;
      tick();
      n = m_cnt[0];
      tick();
      tick();
      en = 1'b0;
      repeat (7) tick();
      chk("drop_led_hold", 32'(led0), 32'(m_led[0]));
      en = 1'b1;
      wait_step("drop_end");
      chk("drop_dwell", cyc - cs, n * PRE + 2 + 7);

      // enable drop during FETCH still completes the load
      wait_phase("fetch", 1, -1);
      en = 1'b0;
      tick();
      chk("fetch_load_step", 32'(step0), 1);
      tick();
      en = 1'b1;

      // restart during HOLD of word2
      wait_phase("w2", 3, 2);
      tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("rs_addr",   32'(pa.addrb), 0);
      chk("rs_led",    32'(led0),     32'h3C);
      chk("rs_nostep", 32'(step0),    0);
      tick();
      chk("rs_step",   32'(step0),    1);
      chk("rs_hold",   32'(led0),     32'h3C);
      tick();
      chk("rs_reload", 32'(led0),     32'h5A);

      // restart during LOAD discards the load
      wait_step("rload");
      exp_led = m_led[0];
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("rload_led",  32'(led0),     32'(exp_led));
      chk("rload_addr", 32'(pa.addrb), 0);

      // asynchronous reset mid-HOLD, then wait in IDLE
      wait_phase("arst", 3, -1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_led0",  32'(led0),     0);
      chk("arst_addr0", 32'(pa.addrb), 0);
      chk("arst_step0", 32'(step0),    0);
      chk("arst_led1",  32'(led1),     0);
      chk("arst_addr1", 32'(pb.addrb), 0);
      model_rst();
      en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) tick();
      en = 1'b1;
      wait_step("after_rst");

      // randomized run
      @(negedge clk);
      rst_n = 1'b0;
      model_rst();
      for (int i = 0; i < 128; i++)
         mem0[i] = {8'($urandom), 24'($urandom_range(0, 3)), 3'($urandom), 1'($urandom % 8 == 0)};
      for (int i = 0; i < 4; i++)
         mem1[i] = {8'($urandom), 24'($urandom_range(0, 3)), 3'($urandom), 1'b0};
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         en      = ($urandom % 8) != 0;
         restart = ($urandom % 64) == 0;
         tick();
      end
      restart = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/prom_sequencer.md
# prom_sequencer

Downstream consumer of the 128×36 pattern PROM's read-only port B in the blinky design. Steps through PROM words, latches an LED pattern and a hold duration from each word, and drives the board LEDs. Holds each pattern for a prescaled interval, then fetches the next word, wrapping on a per-word "last" flag or at the end of the address space.

## Interface

Parameters:
- `ADDR_BITS`, default 7: PROM address width. Depth is 2^ADDR_BITS.
- `LED_WIDTH`, default 8: number of LED outputs. Taken from `doutb[35:36-LED_WIDTH]`.
- `PRESCALE`, default 1000: clock cycles per hold unit, ≥ 1.

Ports:
- `clk`, input, 1: single clock; also the PROM port B clock (`clkb`).
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `en`, input, 1: run enable.
- `restart`, input, 1: synchronous single-cycle request to restart at address 0.
- `addrb`, output, ADDR_BITS: PROM port B address. Registered.
- `doutb`, input, 36: PROM port B data. Valid the cycle after `addrb` is sampled; no output register.
- `led`, output, LED_WIDTH: current pattern. Registered.
- `step`, output, 1: one-cycle pulse when a new word is loaded.

## Operation

Word format:
- `[35:28]`: pattern, for LED_WIDTH = 8.
- `[27:4]`: hold count, 24-bit unsigned. A value of 0 is treated as 1.
- `[3:1]`: reserved, ignored.
- `[0]`: last. When set, the next address is 0.

States: IDLE, FETCH, LOAD, HOLD.
- **IDLE:** initial state after reset. If `en` = 1, go to FETCH; otherwise stay.
- **FETCH:** `addrb` is stable; the PROM samples it on this edge. Always go to LOAD.
- **LOAD:**
  - `led` ← pattern.
  - `hold_cnt` ← max(count, 1).
  - `pre_cnt` ← PRESCALE−1.
  - `step` = 1 during this cycle (decoded from state).
  - `addrb` ← next address. Next address is 0 if last = 1 or `addrb` = 2^ADDR_BITS−1; otherwise `addrb`+1, modulo 2^ADDR_BITS.
  - Go to HOLD.
- **HOLD, `en` = 0:** counters freeze and `led` holds.
- **HOLD, `en` = 1:**
  - If `pre_cnt` ≠ 0: `pre_cnt` decrements.
  - Else, `pre_cnt` ← PRESCALE−1 and `hold_cnt` decrements.
  - When `pre_cnt` = 0 and `hold_cnt` = 1, go to FETCH instead of decrementing.
- **`restart` = 1, in any state:** `addrb` ← 0 and go to FETCH. `led` is unchanged. `restart` has priority over every other transition and over `en`.
- `en` = 0 does not abort FETCH or LOAD; an in-flight fetch completes into HOLD.

Widths:
- `hold_cnt` is 24 bits.
- `pre_cnt` is ceil(log2(PRESCALE)) bits, minimum 1.
- No overflow is possible; all counters decrement only.

## Timing

- Reset values: `addrb` = 0, `led` = 0, `step` = 0, state IDLE, `hold_cnt` = 0, `pre_cnt` = 0.
- Startup: if `en` = 1 at edge E0, then state is FETCH after E0, LOAD after E1, and `led` and `addrb` update at E2. `step` is high between E1 and E2.
- PROM read latency is 1 cycle: data for the address presented in FETCH is consumed in LOAD.
- Dwell per word with `en` held high is max(count, 1) × PRESCALE cycles in HOLD, plus 2 cycles (FETCH + LOAD).
- The period between consecutive `step` pulses equals the dwell.
- Reset asserted mid-HOLD: all outputs return to reset values immediately (asynchronous).
- After reset release, the sequencer waits in IDLE for `en`.
- `restart` in LOAD: the load in progress is discarded and `led` is not updated. The next state is FETCH at address 0.

## Test plan

Behavioural PROM model, 1-cycle read latency. PRESCALE = 4 unless noted.

1. **Startup timing.** Reset, then `en` = 1. Word0 = pattern 0x5A, count 2. Expect `step` at cycle 2, `led` = 0x5A at cycle 3, and the next `step` 10 cycles later (2×4 + 2).
2. **Zero count.** Word1 count = 0. Expect dwell 6 cycles, the same as count = 1.
3. **Wrap on last flag.** Word2 has last = 1. Expect `addrb` to return to 0 after word2 and patterns to repeat word0, word1, word2, word0.
4. **Wrap at end of address space.** No last flags set, ADDR_BITS = 2, count 1. Expect `addrb` sequence 0, 1, 2, 3, 0.
5. **Enable drop mid-HOLD.** Drop `en` mid-HOLD for 7 cycles. Expect `led` to hold and the dwell to extend by exactly 7. Drop `en` during FETCH: expect LOAD to still occur.
6. **Restart and reset.** Pulse `restart` during HOLD of word2: expect FETCH of address 0 on the next cycle, `led` holding word2's pattern until the LOAD. Assert `rst_n` = 0 mid-HOLD: expect `led` = 0 and `addrb` = 0 immediately, with no clock edge needed.
